// File: rtl/stream_decypher.sv
// stream_decypher
// Receive-side stream decryptor. Ciphertext bytes on ui_in are XORed with the
// low byte of a 16-bit Fibonacci LFSR (taps 16,14,13,11). The LFSR is seeded
// through the same pins as two bytes, low byte first. After each consumed byte
// the LFSR advances STEPS_PER_BYTE steps, matching stream_cypher bit-for-bit.
//
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   ena     : clock enable; all registers hold while low
//   ui_in   : ciphertext byte, or seed byte during seed load
//   uio_in  : [0] in_valid, [1] seed_load, [2] seed_hi, [7:3] ignored
//   uo_out  : registered plaintext byte
//   uio_out : [7] parity(uo_out), [6] err (sticky), [5] key_ready,
//             [4] out_valid, [3:0] zero
//   uio_oe  : constant 8'hF0 (upper nibble driven)
//
// state     | meaning
// ----------+-----------------------------------------
// S_IDLE    | no key loaded
// S_SEED_LO | low seed byte captured, waiting for high
// S_READY   | key valid, decrypting

module stream_decypher #(
    parameter logic [15:0] DEFAULT_SEED   = 16'hACE1,
    parameter int          STEPS_PER_BYTE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEED_LO = 2'd1,
        S_READY   = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_lfsr, w_lfsr_nxt, w_lfsr_adv, w_seed_full;
    logic [7:0]  r_seed_lo, w_seed_lo_nxt;
    logic [7:0]  r_uo, w_uo_nxt;
    logic        r_out_valid, w_out_valid_nxt;
    logic        r_err, w_err_nxt;

    logic w_in_valid, w_seed_load, w_seed_hi, w_key_ready;
    logic w_unused_ctrl;

    assign w_in_valid    = uio_in[0];
    assign w_seed_load   = uio_in[1];
    assign w_seed_hi     = uio_in[2];
    assign w_unused_ctrl = ^uio_in[7:3];

    // All STEPS_PER_BYTE shifts are unrolled so one byte is consumed per clock.
    function automatic logic [15:0] lfsr_advance(input logic [15:0] l_in);
        logic [15:0] l;
        l = l_in;
        for (int i = 0; i < STEPS_PER_BYTE; i++) begin
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        return l;
    endfunction

    assign w_lfsr_adv  = lfsr_advance(r_lfsr);
    assign w_seed_full = {ui_in, r_seed_lo};
    assign w_key_ready = (r_state == S_READY);

    always_comb begin
        w_state_nxt     = r_state;
        w_lfsr_nxt      = r_lfsr;
        w_seed_lo_nxt   = r_seed_lo;
        w_uo_nxt        = r_uo;
        w_out_valid_nxt = 1'b0;
        w_err_nxt       = r_err;

        // seed_load wins over in_valid; a coincident ciphertext byte is dropped.
        if (w_seed_load) begin
            if (!w_seed_hi) begin
                w_seed_lo_nxt = ui_in;
                w_state_nxt   = S_SEED_LO;
                w_err_nxt     = 1'b0;
            end else if (r_state == S_SEED_LO) begin
                // An all-zero seed would lock the LFSR; substitute and flag it.
                if (w_seed_full == 16'h0000) begin
                    w_lfsr_nxt = DEFAULT_SEED;
                    w_err_nxt  = 1'b1;
                end else begin
                    w_lfsr_nxt = w_seed_full;
                end
                w_state_nxt = S_READY;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (w_in_valid) begin
            if (r_state == S_READY) begin
                w_uo_nxt        = ui_in ^ r_lfsr[7:0];
                w_lfsr_nxt      = w_lfsr_adv;
                w_out_valid_nxt = 1'b1;
            end else begin
                w_err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lfsr      <= DEFAULT_SEED;
            r_seed_lo   <= 8'h00;
            r_uo        <= 8'h00;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else if (ena) begin
            r_state     <= w_state_nxt;
            r_lfsr      <= w_lfsr_nxt;
            r_seed_lo   <= w_seed_lo_nxt;
            r_uo        <= w_uo_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign uo_out  = r_uo;
    assign uio_out = {^r_uo, r_err, w_key_ready, r_out_valid, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_stream_decypher.sv
module tb_stream_decypher;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_errors = 0;

    stream_decypher dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference keystream: 8 Fibonacci steps, taps 16,14,13,11.
    function automatic logic [15:0] ref_adv(input logic [15:0] s);
        logic [15:0] v;
        logic        b;
        v = s;
        for (int k = 0; k < 8; k++) begin
            b = v[15] ^ v[13] ^ v[12] ^ v[10];
            v = (v << 1) | {15'd0, b};
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        ena    = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_seed(input logic [7:0] lo, input logic [7:0] hi);
        ui_in  = lo;
        uio_in = 8'b0000_0010;
        tick();
        ui_in  = hi;
        uio_in = 8'b0000_0110;
        tick();
        uio_in = 8'h00;
        ui_in  = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] ct);
        ui_in  = ct;
        uio_in = 8'b0000_0001;
        tick();
        uio_in = 8'h00;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #2;
        n_checks++;
        if (uio_oe !== 8'hF0) begin
            n_errors++;
            $display("FAIL reset_oe: got %h want f0", uio_oe);
        end
        tick();
        n_checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_outputs: uo_out=%h uio_out=%h want 00 00", uo_out, uio_out);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        load_seed(8'h34, 8'h12);
        n_checks++;
        if (uio_out[5] !== 1'b1 || uio_out[4] !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_key_ready: uio_out=%h want key_ready=1 out_valid=0", uio_out);
        end
        send_byte(8'hAA);
        n_checks++;
        if (uo_out !== 8'h9E || uio_out !== 8'hB0 || uio_oe !== 8'hF0) begin
            n_errors++;
            $display("FAIL basic_decrypt: uo_out=%h uio_out=%h oe=%h want 9e b0 f0", uo_out, uio_out, uio_oe);
        end
        tick();
        n_checks++;
        if (uo_out !== 8'h9E || uio_out[4] !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_pulse_end: uo_out=%h out_valid=%b want 9e 0", uo_out, uio_out[4]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] m;
        logic [7:0]  pt, ct;
        int          bad;
        bad = 0;
        do_reset();
        load_seed(8'h34, 8'h12);
        m = 16'h1234;
        for (int i = 0; i < 64; i++) begin
            pt     = 8'($urandom_range(0, 255));
            ct     = pt ^ m[7:0];
            m      = ref_adv(m);
            ui_in  = ct;
            uio_in = 8'b0000_0001;
            tick();
            n_checks++;
            if (uo_out !== pt || uio_out[4] !== 1'b1) begin
                n_errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL stream_byte%0d: uo_out=%h valid=%b want %h 1", i, uo_out, uio_out[4], pt);
            end
        end
        uio_in = 8'h00;
        tick();
        n_checks++;
        if (uio_out[4] !== 1'b0) begin
            n_errors++;
            $display("FAIL stream_valid_drop: out_valid=%b want 0", uio_out[4]);
        end
    endtask

    task automatic test_zero_seed();
        do_reset();
        load_seed(8'h00, 8'h00);
        n_checks++;
        if (uio_out[6] !== 1'b1 || uio_out[5] !== 1'b1) begin
            n_errors++;
            $display("FAIL zero_seed_flags: err=%b key_ready=%b want 1 1", uio_out[6], uio_out[5]);
        end
        send_byte(8'h00);
        n_checks++;
        if (uo_out !== 8'hE1) begin
            n_errors++;
            $display("FAIL zero_seed_decrypt: uo_out=%h want e1", uo_out);
        end
    endtask

    task automatic test_no_key();
        do_reset();
        send_byte(8'h55);
        n_checks++;
        if (uio_out[4] !== 1'b0 || uo_out !== 8'h00 || uio_out[6] !== 1'b1) begin
            n_errors++;
            $display("FAIL nokey_drop: uo_out=%h uio_out=%h want 00 with err=1 valid=0", uo_out, uio_out);
        end
        ui_in  = 8'h11;
        uio_in = 8'b0000_0010;
        tick();
        uio_in = 8'h00;
        n_checks++;
        if (uio_out[6] !== 1'b0 || uio_out[5] !== 1'b0) begin
            n_errors++;
            $display("FAIL nokey_err_clear: err=%b key_ready=%b want 0 0", uio_out[6], uio_out[5]);
        end
    endtask

    task automatic test_precedence();
        do_reset();
        load_seed(8'h34, 8'h12);
        send_byte(8'hAA);
        ui_in  = 8'h77;
        uio_in = 8'b0000_0011;
        tick();
        uio_in = 8'h00;
        n_checks++;
        if (uio_out[4] !== 1'b0 || uio_out[5] !== 1'b0 || uo_out !== 8'h9E) begin
            n_errors++;
            $display("FAIL prec_drop: uo_out=%h valid=%b key_ready=%b want 9e 0 0", uo_out, uio_out[4], uio_out[5]);
        end
        ui_in  = 8'h56;
        uio_in = 8'b0000_0110;
        tick();
        uio_in = 8'h00;
        send_byte(8'h00);
        n_checks++;
        if (uo_out !== 8'h77 || uio_out[5] !== 1'b1) begin
            n_errors++;
            $display("FAIL prec_new_seed: uo_out=%h key_ready=%b want 77 1", uo_out, uio_out[5]);
        end
    endtask

    task automatic test_hi_in_ready();
        logic [15:0] m;
        do_reset();
        load_seed(8'h34, 8'h12);
        ui_in  = 8'hFF;
        uio_in = 8'b0000_0110;
        tick();
        uio_in = 8'h00;
        n_checks++;
        if (uio_out[6] !== 1'b1 || uio_out[5] !== 1'b1) begin
            n_errors++;
            $display("FAIL hi_ready_flags: err=%b key_ready=%b want 1 1", uio_out[6], uio_out[5]);
        end
        m = 16'h1234;
        send_byte(8'h0F);
        n_checks++;
        if (uo_out !== (8'h0F ^ m[7:0])) begin
            n_errors++;
            $display("FAIL hi_ready_lfsr_kept: uo_out=%h want %h", uo_out, 8'h0F ^ m[7:0]);
        end
    endtask

    task automatic test_ena_hold();
        logic [15:0] m;
        logic [7:0]  exp1;
        do_reset();
        load_seed(8'h34, 8'h12);
        m = 16'h1234;
        send_byte(8'h3C);
        m = ref_adv(m);
        ena    = 1'b0;
        ui_in  = 8'hC3;
        uio_in = 8'b0000_0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (uo_out !== (8'h3C ^ 8'h34) || uio_out[4] !== 1'b1) begin
                n_errors++;
                $display("FAIL ena_hold%0d: uo_out=%h valid=%b want %h 1", i, uo_out, uio_out[4], 8'h3C ^ 8'h34);
            end
        end
        ena  = 1'b1;
        exp1 = 8'hC3 ^ m[7:0];
        tick();
        uio_in = 8'h00;
        n_checks++;
        if (uo_out !== exp1 || uio_out[4] !== 1'b1) begin
            n_errors++;
            $display("FAIL ena_resume: uo_out=%h valid=%b want %h 1", uo_out, uio_out[4], exp1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        load_seed(8'h34, 8'h12);
        send_byte(8'hAA);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            n_errors++;
            $display("FAIL async_reset: uo_out=%h uio_out=%h want 00 00", uo_out, uio_out);
        end
        tick();
        rst_n = 1'b1;
        tick();
        send_byte(8'hAA);
        n_checks++;
        if (uio_out[4] !== 1'b0 || uio_out[6] !== 1'b1 || uo_out !== 8'h00) begin
            n_errors++;
            $display("FAIL async_blocked: uo_out=%h uio_out=%h want 00 with err=1 valid=0", uo_out, uio_out);
        end
        load_seed(8'h34, 8'h12);
        send_byte(8'hAA);
        n_checks++;
        if (uo_out !== 8'h9E || uio_out[4] !== 1'b1) begin
            n_errors++;
            $display("FAIL async_reload: uo_out=%h valid=%b want 9e 1", uo_out, uio_out[4]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero_seed();
        test_no_key();
        test_precedence();
        test_hi_in_ready();
        test_ena_hold();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
